pipe_stage_chain: RTL and testbench

- Parametrised in-order pipeline register chain that replaces hand-instantiated per-stage buffers and global stall/flush wiring in the core.
- Each of STAGES slots holds a WIDTH-bit payload plus a valid bit, with per-stage hold and flush.
- Optional bubble collapsing lets younger stages advance into empty slots while older stages are held.
- Sits between the decode/execute/memory/writeback logic; provides tap outputs for the hazard/forwarding logic.

---
 rtl/pipe_stage_chain_pkg.sv | 21 ++
 rtl/pipe_stage_chain_slot.sv | 45 ++++
 rtl/pipe_stage_chain.sv | 101 ++++++++++
 tb/tb_pipe_stage_chain.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_chain_pkg.sv
// Shared types and helpers for the pipeline register chain and the hazard unit.
package pipe_stage_chain_pkg;

  localparam int MAX_SLOTS = 64;

  typedef struct packed {
    logic hold;
    logic flush;
  } stage_ctrl_t;

  // Population count over up to MAX_SLOTS valid bits; callers zero-extend narrower vectors.
  function automatic logic [6:0] popcount(input logic [MAX_SLOTS-1:0] bits);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      n = n + 7'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_chain_slot.sv
// One pipeline slot: valid bit plus payload, with load / clear / keep select.
module pipe_slot #(
  parameter int WIDTH      = 32,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: state registers use non-blocking assignments so every slot samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  generate
    if (RESET_DATA) begin : g_rst_data
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data <= '0;
        end else if (load) begin
          data <= d;
        end
      end
    end else begin : g_no_rst_data
      // NOTE: payload is qualified by valid, so leaving it out of reset saves reset fan-out.
      always_ff @(posedge clk) begin
        if (load) begin
          data <= d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_chain.sv
// In-order pipeline register chain with per-slot hold/flush and optional bubble collapsing.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STAGES     = 4,
  parameter bit COLLAPSE   = 1'b1,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic [STAGES-1:0]            hold,
  input  logic [STAGES-1:0]            flush,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*WIDTH-1:0]      stage_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(STAGES+1);

  stage_ctrl_t        ctrl   [STAGES];
  logic [WIDTH-1:0]   slot_d [STAGES];
  logic [WIDTH-1:0]   slot_q [STAGES];
  logic [STAGES-1:0]  v, go, rdy, load, clear, v_next;
  logic               accept;

  // Ready ripples from the tail toward slot 0; dn is the readiness of the next-older slot.
  always_comb begin
    logic dn;
    logic chain_ok;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    dn       = out_ready;
    chain_ok = out_ready;
    go       = '0;
    rdy      = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      go[i] = v[i] & ~ctrl[i].hold & ~ctrl[i].flush & dn;
      if (COLLAPSE) begin
        rdy[i] = ~v[i] | ctrl[i].flush | go[i];
      end else begin
        chain_ok = chain_ok & (~v[i] | ctrl[i].flush | ~ctrl[i].hold);
        rdy[i]   = chain_ok;
      end
      dn = rdy[i];
    end
  end

  assign accept = in_valid & rdy[0];
  assign clear  = go | flush;
  assign v_next = load | (v & ~clear);

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_slot
      assign ctrl[i] = '{hold: hold[i], flush: flush[i]};

      if (i == 0) begin : g_head
        assign load[i]   = accept;
        assign slot_d[i] = in_data;
      end else begin : g_body
        assign load[i]   = go[i-1];
        assign slot_d[i] = slot_q[i-1];
      end

      pipe_slot #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
      ) u_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (load[i]),
        .clear (clear[i]),
        .d     (slot_d[i]),
        .valid (v[i]),
        .data  (slot_q[i])
      );

      assign stage_data[i*WIDTH +: WIDTH] = slot_q[i];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= OCC_W'(popcount(MAX_SLOTS'(v_next)));
    end
  end

  // Upstream sees ready throughout reset even when a rigid chain would be blocked.
  assign in_ready    = rdy[0] | rst;
  assign out_valid   = v[STAGES-1] & ~hold[STAGES-1] & ~flush[STAGES-1];
  assign out_data    = slot_q[STAGES-1];
  assign stage_valid = v;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: collapsing instance plus a rigid instance.
module tb_pipe_stage_chain;

  localparam int W  = 8;
  localparam int S  = 3;
  localparam int OW = $clog2(S+1);

  logic           clk;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   in_data, out_data;
  logic [S-1:0]   hold, flush, stage_valid;
  logic [S*W-1:0] stage_data;
  logic [OW-1:0]  occupancy;

  logic           r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [W-1:0]   r_in_data, r_out_data;
  logic [S-1:0]   r_hold, r_flush, r_stage_valid;
  logic [S*W-1:0] r_stage_data;
  logic [OW-1:0]  r_occupancy;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] sb[$];

  pipe_stage_chain #(.WIDTH(W), .STAGES(S), .COLLAPSE(1'b1), .RESET_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .hold(hold), .flush(flush), .stage_valid(stage_valid), .stage_data(stage_data),
    .occupancy(occupancy)
  );

  pipe_stage_chain #(.WIDTH(W), .STAGES(S), .COLLAPSE(1'b0), .RESET_DATA(1'b0)) dut_rigid (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
    .hold(r_hold), .flush(r_flush), .stage_valid(r_stage_valid), .stage_data(r_stage_data),
    .occupancy(r_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sample at the falling edge: pop expected on an output transfer, push on an input accept.
  task automatic observe();
    logic [W-1:0] exp;
    @(negedge clk);
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got=%h exp=none", out_data);
      end else begin
        exp = sb.pop_front();
        if (out_data !== exp) begin
          errors++;
          $display("FAIL sb_out_data got=%h exp=%h", out_data, exp);
        end
      end
    end
    if (in_valid && in_ready) sb.push_back(in_data);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    observe();
    advance();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) begin
      observe();
      advance();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_empty got=%0d items left exp=0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; hold = '0; flush = '0;
    r_in_valid = 1'b0; r_in_data = '0; r_out_ready = 1'b0; r_hold = '0; r_flush = '0;
    repeat (2) @(negedge clk);
    checks++; if (stage_valid !== '0) begin errors++; $display("FAIL rst_valid got=%b exp=000", stage_valid); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (stage_data !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", stage_data); end
    checks++; if (r_in_ready !== 1'b1) begin errors++; $display("FAIL rst_rigid_in_ready got=%b exp=1", r_in_ready); end
    advance();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (r_in_ready !== 1'b0) begin errors++; $display("FAIL rigid_blocked_empty got=%b exp=0", r_in_ready); end
    advance();
  endtask

  task automatic test_stream();
    logic [W-1:0] vals [3];
    int peak;
    vals = '{8'h11, 8'h22, 8'h33};
    peak = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 3);
      in_data  = (c < 3) ? vals[c] : '0;
      observe();
      if (int'(occupancy) > peak) peak = int'(occupancy);
      if (c >= 3 && c <= 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== vals[c-3]) begin
          errors++;
          $display("FAIL stream_cycle%0d got=%b/%h exp=1/%h", c, out_valid, out_data, vals[c-3]);
        end
      end
      advance();
    end
    in_valid = 1'b0;
    checks++; if (peak != 3) begin errors++; $display("FAIL stream_peak_occ got=%0d exp=3", peak); end
    drain(2);
  endtask

  task automatic test_collapse();
    out_ready = 1'b0;
    send(8'h11);
    observe(); advance();
    send(8'h33);
    observe();
    checks++;
    if (stage_valid !== 3'b101 || stage_data[7:0] !== 8'h33 || stage_data[23:16] !== 8'h11) begin
      errors++;
      $display("FAIL collapse_setup got=%b/%h exp=101/11xx33", stage_valid, stage_data);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL collapse_ready_gap got=%b exp=1", in_ready); end
    advance();
    in_valid = 1'b1; in_data = 8'h44;
    observe();
    checks++;
    if (stage_valid !== 3'b110 || stage_data[15:8] !== 8'h33) begin
      errors++;
      $display("FAIL collapse_squeeze got=%b/%h exp=110/33 in s1", stage_valid, stage_data);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL collapse_ready_s0_empty got=%b exp=1", in_ready); end
    advance();
    in_data = 8'h55;
    observe();
    checks++; if (stage_valid !== 3'b111) begin errors++; $display("FAIL collapse_full got=%b exp=111", stage_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL collapse_ready_full got=%b exp=0", in_ready); end
    advance();
    drain(5);
  endtask

  task automatic test_rigid();
    r_out_ready = 1'b1;
    r_in_valid = 1'b1; r_in_data = 8'h11; advance();
    r_in_valid = 1'b0; advance();
    r_in_valid = 1'b1; r_in_data = 8'h33; advance();
    r_in_valid = 1'b0; r_out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      observe();
      checks++;
      if (r_in_ready !== 1'b0 || r_stage_valid !== 3'b101 || r_stage_data[7:0] !== 8'h33 || r_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rigid_frozen%0d got=rdy%b/%b/%h exp=rdy0/101/33", c, r_in_ready, r_stage_valid, r_stage_data[7:0]);
      end
      advance();
    end
    r_out_ready = 1'b1;
    observe();
    checks++;
    if (r_in_ready !== 1'b1 || r_out_data !== 8'h11) begin
      errors++;
      $display("FAIL rigid_release got=rdy%b/%h exp=rdy1/11", r_in_ready, r_out_data);
    end
    advance();
    observe();
    checks++;
    if (r_stage_valid !== 3'b010 || r_stage_data[15:8] !== 8'h33) begin
      errors++;
      $display("FAIL rigid_advance got=%b/%h exp=010/33 in s1", r_stage_valid, r_stage_data);
    end
    advance();
    repeat (3) advance();
  endtask

  task automatic test_hold_mid();
    out_ready = 1'b0;
    send(8'hA1); send(8'hA2); send(8'hA3);
    hold = 3'b010; out_ready = 1'b1;
    observe(); advance();
    hold = '0;
    observe();
    checks++;
    if (stage_valid !== 3'b011 || stage_data[15:8] !== 8'hA2 || stage_data[7:0] !== 8'hA3) begin
      errors++;
      $display("FAIL hold_mid got=%b/%h exp=011/A2A3", stage_valid, stage_data);
    end
    advance();
    observe();
    checks++;
    if (stage_valid !== 3'b110 || stage_data[23:16] !== 8'hA2 || stage_data[15:8] !== 8'hA3) begin
      errors++;
      $display("FAIL hold_release got=%b/%h exp=110/A2A3", stage_valid, stage_data);
    end
    advance();
    drain(4);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(8'hC1); send(8'hC2); send(8'hC3);
    flush = 3'b011; in_valid = 1'b1; in_data = 8'h5C;
    observe();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    advance();
    // C2 and C3 were killed in place; only C1 and the new 5C remain in flight.
    sb.delete(2);
    sb.delete(1);
    flush = '0; in_valid = 1'b0;
    observe();
    checks++;
    if (stage_valid !== 3'b101 || stage_data[7:0] !== 8'h5C || stage_data[23:16] !== 8'hC1) begin
      errors++;
      $display("FAIL flush_state got=%b/%h exp=101/C1xx5C", stage_valid, stage_data);
    end
    checks++; if (occupancy !== OW'(2)) begin errors++; $display("FAIL flush_occ got=%0d exp=2", occupancy); end
    advance();
    flush = 3'b100; out_ready = 1'b1;
    observe();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_tail_hidden got=%b exp=0", out_valid); end
    advance();
    sb.delete(0);
    flush = '0;
    drain(4);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(8'h61); send(8'h62);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (stage_valid !== '0 || out_valid !== 1'b0 || occupancy !== '0) begin
      errors++;
      $display("FAIL async_rst got=%b/%b/%0d exp=000/0/0", stage_valid, out_valid, occupancy);
    end
    #1 rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 0);
      in_data  = 8'h77;
      observe();
      if (c == 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_early_out got=%b exp=0", out_valid); end
      end
      if (c == 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
          errors++;
          $display("FAIL rst_first_item got=%b/%h exp=1/77", out_valid, out_data);
        end
      end
      advance();
    end
    drain(1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_collapse();
    test_rigid();
    test_hold_mid();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
